// File: rtl/ace_pkg.sv
// Shared definitions for the ACE CCU snoop collector: CRRESP bit layout
// and the head-transaction FSM states.
package ace_pkg;

  localparam int unsigned CrRespW = 5;

  // CRRESP bit positions
  localparam int unsigned CR_DATA_TRANSFER = 0;
  localparam int unsigned CR_ERROR         = 1;
  localparam int unsigned CR_PASS_DIRTY    = 2;
  localparam int unsigned CR_IS_SHARED     = 3;
  localparam int unsigned CR_WAS_UNIQUE    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESP    = 2'd2,
    ST_DATA    = 2'd3
  } ccu_state_e;

endpackage

// File: rtl/ace_ccu_snoop_collector_if.sv
// Signal bundle around the snoop collector: control, per-cache CR/CD
// channels and the merged CR / forwarded CD outputs.
interface ace_ccu_snoop_collector_if
  import ace_pkg::*;
#(
  parameter int unsigned NumOup    = 2,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdxWidth  = 2
);
  logic                          ctrl_valid;
  logic                          ctrl_ready;
  logic [NumOup-1:0]             ctrl_sel;
  logic [IdxWidth-1:0]           ctrl_idx;
  logic [NumOup-1:0]             cr_valids;
  logic [NumOup-1:0]             cr_readies;
  logic [NumOup*CrRespW-1:0]     cr_resps;
  logic [NumOup-1:0]             cd_valids;
  logic [NumOup-1:0]             cd_readies;
  logic [NumOup*DataWidth-1:0]   cd_datas;
  logic [NumOup-1:0]             cd_lasts;
  logic                          cr_valid;
  logic                          cr_ready;
  logic [CrRespW-1:0]            cr_resp;
  logic [IdxWidth-1:0]           cr_idx;
  logic                          cd_valid;
  logic                          cd_ready;
  logic [DataWidth-1:0]          cd_data;
  logic                          cd_last;
  logic [IdxWidth-1:0]           cd_idx;
  logic                          busy;

  // Environment side: issues snoops, returns cache responses, sinks outputs
  modport master (
    output ctrl_valid, ctrl_sel, ctrl_idx, cr_valids, cr_resps,
           cd_valids, cd_datas, cd_lasts, cr_ready, cd_ready,
    input  ctrl_ready, cr_readies, cd_readies, cr_valid, cr_resp, cr_idx,
           cd_valid, cd_data, cd_last, cd_idx, busy
  );

  // Collector side
  modport slave (
    input  ctrl_valid, ctrl_sel, ctrl_idx, cr_valids, cr_resps,
           cd_valids, cd_datas, cd_lasts, cr_ready, cd_ready,
    output ctrl_ready, cr_readies, cd_readies, cr_valid, cr_resp, cr_idx,
           cd_valid, cd_data, cd_last, cd_idx, busy
  );
endinterface

// File: rtl/ace_ccu_cr_merge.sv
// Combinational merge of collected snoop responses: OR of all bits, with
// Error added when more than one cache passes dirty data.
module ace_ccu_cr_merge
  import ace_pkg::*;
#(
  parameter int unsigned NumOup = 2
) (
  input  logic [NumOup*CrRespW-1:0] resps_i,
  input  logic [NumOup-1:0]         mask_i,
  output logic [CrRespW-1:0]        resp_o
);
  logic dirty_seen, dirty_multi;

  // OR-reduce masked responses and detect multiple PassDirty
  always_comb begin
    resp_o      = '0;
    dirty_seen  = 1'b0;
    dirty_multi = 1'b0;
    for (int i = 0; i < NumOup; i++) begin
      if (mask_i[i]) begin
        resp_o = resp_o | resps_i[i*CrRespW +: CrRespW];
        if (resps_i[i*CrRespW + CR_PASS_DIRTY]) begin
          dirty_multi = dirty_multi | dirty_seen;
          dirty_seen  = 1'b1;
        end
      end
    end
    if (dirty_multi) resp_o[CR_ERROR] = 1'b1;
  end
endmodule

// File: rtl/stream_fifo_optimal_wrap.sv
// Ready/valid FIFO holding in-flight snoop control entries.
module stream_fifo_optimal_wrap #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  assign ready_o = (cnt_q != CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // Next pointer and occupancy
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array
  // NOTE: storage is not reset; occupancy is, so stale entries are never visible.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/ace_ccu_snoop_collector.sv
// Collects snoop responses from the targeted caches, returns one merged CR
// and forwards the data of the lowest-index DataTransfer cache while
// draining any other data-bearing caches. Transactions complete in order.
module ace_ccu_snoop_collector
  import ace_pkg::*;
#(
  parameter int unsigned NumOup    = 2,
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdxWidth  = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ctrl_valid_i,
  output logic                        ctrl_ready_o,
  input  logic [NumOup-1:0]           ctrl_sel_i,
  input  logic [IdxWidth-1:0]         ctrl_idx_i,
  input  logic [NumOup-1:0]           cr_valids_i,
  output logic [NumOup-1:0]           cr_readies_o,
  input  logic [NumOup*CrRespW-1:0]   cr_resps_i,
  input  logic [NumOup-1:0]           cd_valids_i,
  output logic [NumOup-1:0]           cd_readies_o,
  input  logic [NumOup*DataWidth-1:0] cd_datas_i,
  input  logic [NumOup-1:0]           cd_lasts_i,
  output logic                        cr_valid_o,
  input  logic                        cr_ready_i,
  output logic [CrRespW-1:0]          cr_resp_o,
  output logic [IdxWidth-1:0]         cr_idx_o,
  output logic                        cd_valid_o,
  input  logic                        cd_ready_i,
  output logic [DataWidth-1:0]        cd_data_o,
  output logic                        cd_last_o,
  output logic [IdxWidth-1:0]         cd_idx_o,
  output logic                        busy_o
);
  localparam int unsigned OwnerW = (NumOup > 1) ? $clog2(NumOup) : 1;

  ccu_state_e                state_q, state_d;
  logic [NumOup-1:0]         sel_q, sel_d, coll_q, coll_d, pend_q, pend_d;
  logic [IdxWidth-1:0]       idx_q, idx_d;
  logic [NumOup*CrRespW-1:0] resps_q, resps_d;
  logic [CrRespW-1:0]        merged_q, merged_d, merge_out;
  logic [OwnerW-1:0]         owner_q, owner_d;
  logic [NumOup-1:0]         cr_rdy, cd_rdy, accept, dt_mask;
  logic                      fifo_ready, fifo_valid, fifo_pop;
  logic [NumOup-1:0]         head_sel;
  logic [IdxWidth-1:0]       head_idx;
  logic                      in_data, owner_valid;

  stream_fifo_optimal_wrap #(
    .Depth (MaxTrans),
    .Width (NumOup + IdxWidth)
  ) i_ctrl_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (ctrl_valid_i),
    .ready_o (fifo_ready),
    .data_i  ({ctrl_idx_i, ctrl_sel_i}),
    .valid_o (fifo_valid),
    .ready_i (fifo_pop),
    .data_o  ({head_idx, head_sel})
  );

  ace_ccu_cr_merge #(.NumOup(NumOup)) i_cr_merge (
    .resps_i (resps_d),
    .mask_i  (coll_d),
    .resp_o  (merge_out)
  );

  // Head-transaction FSM and per-port bookkeeping
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    coll_d   = coll_q;
    resps_d  = resps_q;
    merged_d = merged_q;
    pend_d   = pend_q;
    owner_d  = owner_q;
    fifo_pop = 1'b0;
    cr_rdy   = '0;
    cd_rdy   = '0;
    accept   = cr_valids_i & cr_rdy;
    for (int i = 0; i < NumOup; i++)
      dt_mask[i] = coll_q[i] & resps_q[i*CrRespW + CR_DATA_TRANSFER];
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_valid) begin
          sel_d  = head_sel;
          idx_d  = head_idx;
          coll_d = '0;
          if (head_sel == '0) begin
            merged_d = '0;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        cr_rdy = sel_q & ~coll_q;
        accept = cr_valids_i & cr_rdy;
        for (int i = 0; i < NumOup; i++)
          if (accept[i]) resps_d[i*CrRespW +: CrRespW] = cr_resps_i[i*CrRespW +: CrRespW];
        coll_d = coll_q | accept;
        if (coll_d == sel_q) begin
          merged_d = merge_out;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (cr_ready_i) begin
          if (merged_q[CR_DATA_TRANSFER]) begin
            pend_d = dt_mask;
            for (int i = NumOup - 1; i >= 0; i--)
              if (dt_mask[i]) owner_d = OwnerW'(i);
            state_d = ST_DATA;
          end else begin
            fifo_pop = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        for (int i = 0; i < NumOup; i++) begin
          if (pend_q[i]) begin
            cd_rdy[i] = (OwnerW'(i) == owner_q) ? cd_ready_i : 1'b1;
            if (cd_valids_i[i] && cd_rdy[i] && cd_lasts_i[i]) pend_d[i] = 1'b0;
          end
        end
        if (pend_d == '0) begin
          fifo_pop = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      idx_q    <= '0;
      coll_q   <= '0;
      resps_q  <= '0;
      merged_q <= '0;
      pend_q   <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      coll_q   <= coll_d;
      resps_q  <= resps_d;
      merged_q <= merged_d;
      pend_q   <= pend_d;
      owner_q  <= owner_d;
    end
  end

  assign in_data     = (state_q == ST_DATA);
  assign owner_valid = in_data & pend_q[owner_q] & cd_valids_i[owner_q];

  assign ctrl_ready_o = fifo_ready & rst_ni;
  assign cr_readies_o = cr_rdy;
  assign cd_readies_o = cd_rdy;
  assign cr_valid_o   = (state_q == ST_RESP);
  assign cr_resp_o    = cr_valid_o ? merged_q : '0;
  assign cr_idx_o     = cr_valid_o ? idx_q : '0;
  assign cd_valid_o   = owner_valid;
  assign cd_data_o    = in_data ? cd_datas_i[int'(owner_q)*DataWidth +: DataWidth] : '0;
  assign cd_last_o    = in_data & cd_lasts_i[owner_q];
  assign cd_idx_o     = in_data ? idx_q : '0;
  assign busy_o       = fifo_valid | (state_q != ST_IDLE);
endmodule

// File: tb/tb_ace_ccu_snoop_collector.sv
// Directed self-checking bench for the snoop collector (3 caches, 4-deep queue).
module tb_ace_ccu_snoop_collector;
  localparam int unsigned NumOup    = 3;
  localparam int unsigned MaxTrans  = 4;
  localparam int unsigned DataWidth = 16;
  localparam int unsigned IdxWidth  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ace_ccu_snoop_collector_if #(
    .NumOup(NumOup), .DataWidth(DataWidth), .IdxWidth(IdxWidth)
  ) bus ();

  ace_ccu_snoop_collector #(
    .NumOup(NumOup), .MaxTrans(MaxTrans), .DataWidth(DataWidth), .IdxWidth(IdxWidth)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ctrl_valid_i (bus.ctrl_valid),
    .ctrl_ready_o (bus.ctrl_ready),
    .ctrl_sel_i   (bus.ctrl_sel),
    .ctrl_idx_i   (bus.ctrl_idx),
    .cr_valids_i  (bus.cr_valids),
    .cr_readies_o (bus.cr_readies),
    .cr_resps_i   (bus.cr_resps),
    .cd_valids_i  (bus.cd_valids),
    .cd_readies_o (bus.cd_readies),
    .cd_datas_i   (bus.cd_datas),
    .cd_lasts_i   (bus.cd_lasts),
    .cr_valid_o   (bus.cr_valid),
    .cr_ready_i   (bus.cr_ready),
    .cr_resp_o    (bus.cr_resp),
    .cr_idx_o     (bus.cr_idx),
    .cd_valid_o   (bus.cd_valid),
    .cd_ready_i   (bus.cd_ready),
    .cd_data_o    (bus.cd_data),
    .cd_last_o    (bus.cd_last),
    .cd_idx_o     (bus.cd_idx),
    .busy_o       (bus.busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pushes one control entry; returns at the negedge after the push edge.
  task automatic issue(input logic [NumOup-1:0] sel, input logic [IdxWidth-1:0] idx);
    bus.ctrl_valid = 1'b1;
    bus.ctrl_sel   = sel;
    bus.ctrl_idx   = idx;
    #1 check("issue_ready", bus.ctrl_ready, 1);
    tick();
    bus.ctrl_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.ctrl_valid = 1'b0;
    bus.ctrl_sel   = '0;
    bus.ctrl_idx   = '0;
    bus.cr_valids  = '0;
    bus.cr_resps   = '0;
    bus.cd_valids  = '0;
    bus.cd_datas   = '0;
    bus.cd_lasts   = '0;
    bus.cr_ready   = 1'b0;
    bus.cd_ready   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]         a_dat, b_dat;
    logic [IdxWidth-1:0] exp_idx [5];
    int                  lasts, got, cyc;
    logic                push_now;

    idle_inputs();
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl_ready", bus.ctrl_ready, 0);
    check("rst_cr_valid", bus.cr_valid, 0);
    check("rst_cd_valid", bus.cd_valid, 0);
    check("rst_cr_readies", bus.cr_readies, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // Snoop 1: sel=0b11, CR0=0x08 then CR1=0x00 -> 0x08, idx 2
    issue(3'b011, 2'd2);
    tick();
    check("t1_collect_readies", bus.cr_readies, 3'b011);
    check("t1_busy", bus.busy, 1);
    bus.cr_valids = 3'b001;
    bus.cr_resps  = {5'h00, 5'h00, 5'h08};
    tick();
    check("t1_readies_after_p0", bus.cr_readies, 3'b010);
    check("t1_no_early_valid", bus.cr_valid, 0);
    bus.cr_valids = 3'b010;
    bus.cr_resps  = {5'h00, 5'h00, 5'h00};
    tick();
    bus.cr_valids = '0;
    check("t1_cr_valid", bus.cr_valid, 1);
    check("t1_cr_resp", bus.cr_resp, 5'h08);
    check("t1_cr_idx", bus.cr_idx, 2'd2);
    tick();
    check("t1_hold_valid", bus.cr_valid, 1);
    check("t1_hold_resp", bus.cr_resp, 5'h08);
    bus.cr_ready = 1'b1;
    tick();
    bus.cr_ready = 1'b0;
    check("t1_done_valid", bus.cr_valid, 0);
    check("t1_done_busy", bus.busy, 0);

    // Snoop 2: CR0=0x05, CR1=0x01, four beats each; port0 forwarded, port1 drained
    issue(3'b011, 2'd1);
    tick();
    bus.cr_valids = 3'b011;
    bus.cr_resps  = {5'h00, 5'h01, 5'h05};
    #1 check("t2_readies", bus.cr_readies, 3'b011);
    tick();
    bus.cr_valids = '0;
    check("t2_cr_valid", bus.cr_valid, 1);
    check("t2_cr_resp", bus.cr_resp, 5'h05);
    check("t2_cr_idx", bus.cr_idx, 2'd1);
    bus.cr_ready = 1'b1;
    tick();
    bus.cr_ready = 1'b0;
    lasts = 0;
    for (int k = 0; k < 4; k++) begin
      a_dat = 16'hA0 + 16'(k);
      b_dat = 16'hB0 + 16'(k);
      bus.cd_valids = 3'b011;
      bus.cd_datas  = {16'h0000, b_dat, a_dat};
      bus.cd_lasts  = (k == 3) ? 3'b011 : 3'b000;
      bus.cd_ready  = 1'b1;
      #1;
      check("t2_cd_valid", bus.cd_valid, 1);
      check("t2_cd_data", bus.cd_data, a_dat);
      check("t2_cd_last", bus.cd_last, (k == 3));
      check("t2_cd_readies", bus.cd_readies, 3'b011);
      check("t2_cd_idx", bus.cd_idx, 2'd1);
      if (bus.cd_last) lasts++;
      tick();
    end
    bus.cd_valids = '0;
    bus.cd_lasts  = '0;
    bus.cd_ready  = 1'b0;
    check("t2_last_count", lasts, 1);
    check("t2_done_busy", bus.busy, 0);
    check("t2_done_cd_valid", bus.cd_valid, 0);

    // Snoop 3: sel=0b101, both PassDirty -> 0x06
    issue(3'b101, 2'd3);
    tick();
    check("t3_readies", bus.cr_readies, 3'b101);
    bus.cr_valids = 3'b111;
    bus.cr_resps  = {5'h04, 5'h1F, 5'h04};
    tick();
    bus.cr_valids = '0;
    check("t3_cr_resp", bus.cr_resp, 5'h06);
    check("t3_cr_idx", bus.cr_idx, 2'd3);
    bus.cr_ready = 1'b1;
    tick();
    bus.cr_ready = 1'b0;
    check("t3_done_busy", bus.busy, 0);
    check("t3_no_cd", bus.cd_valid, 0);

    // Snoop 4: empty sel -> response 0 within 2 cycles, no CD
    issue(3'b000, 2'd3);
    tick();
    check("t4_cr_valid", bus.cr_valid, 1);
    check("t4_cr_resp", bus.cr_resp, 5'h00);
    check("t4_cr_readies", bus.cr_readies, 0);
    bus.cr_ready = 1'b1;
    tick();
    bus.cr_ready = 1'b0;
    check("t4_no_cd", bus.cd_valid, 0);
    check("t4_cd_readies", bus.cd_readies, 0);
    check("t4_done_busy", bus.busy, 0);

    // Queue full: MaxTrans+1 entries with CR output stalled, then in-order drain
    for (int k = 0; k < 5; k++) begin
      exp_idx[k] = IdxWidth'(k);
      bus.ctrl_valid = 1'b1;
      bus.ctrl_sel   = '0;
      bus.ctrl_idx   = IdxWidth'(k);
      #1 check("t5_ctrl_ready", bus.ctrl_ready, (k < MaxTrans));
      if (k < 4) tick();
    end
    bus.cr_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 60) begin
      if (bus.cr_valid) begin
        check("t5_order_idx", bus.cr_idx, exp_idx[got]);
        got++;
      end
      push_now = bus.ctrl_valid & bus.ctrl_ready;
      tick();
      if (push_now) bus.ctrl_valid = 1'b0;
      cyc++;
    end
    check("t5_all_done", got, 5);
    check("t5_ctrl_pushed", bus.ctrl_valid, 0);
    check("t5_done_busy", bus.busy, 0);
    bus.cr_ready = 1'b0;

    // Snoop 6: reset pulsed on beat 2 of 4, then a fresh snoop
    issue(3'b001, 2'd2);
    tick();
    bus.cr_valids = 3'b001;
    bus.cr_resps  = {5'h00, 5'h00, 5'h01};
    tick();
    bus.cr_valids = '0;
    bus.cr_ready  = 1'b1;
    tick();
    bus.cr_ready  = 1'b0;
    bus.cd_valids = 3'b001;
    bus.cd_datas  = {16'h0, 16'h0, 16'hC0};
    bus.cd_ready  = 1'b1;
    #1 check("t6_beat0", bus.cd_data, 16'hC0);
    tick();
    bus.cd_datas = {16'h0, 16'h0, 16'hC1};
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_cd_valid", bus.cd_valid, 0);
    check("t6_rst_cd_data", bus.cd_data, 0);
    check("t6_rst_cd_readies", bus.cd_readies, 0);
    check("t6_rst_ctrl_ready", bus.ctrl_ready, 0);
    check("t6_rst_busy", bus.busy, 0);
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_post_busy", bus.busy, 0);
    check("t6_post_cr_valid", bus.cr_valid, 0);
    check("t6_post_cd_valid", bus.cd_valid, 0);
    issue(3'b010, 2'd1);
    tick();
    check("t6_new_readies", bus.cr_readies, 3'b010);
    bus.cr_valids = 3'b010;
    bus.cr_resps  = {5'h00, 5'h10, 5'h00};
    tick();
    bus.cr_valids = '0;
    check("t6_new_resp", bus.cr_resp, 5'h10);
    check("t6_new_idx", bus.cr_idx, 2'd1);
    bus.cr_ready = 1'b1;
    tick();
    bus.cr_ready = 1'b0;
    check("t6_new_done", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ace_ccu_snoop_collector.md
ACE_CCU_SNOOP_COLLECTOR -- requirements
Module: ace_ccu_snoop_collector

Interface
REQ-001 SHALL have parameter NumOup, default 2: number of snooped caches, range 1..16.
REQ-002 SHALL have parameter MaxTrans, default 4: depth of the in-flight snoop control queue, range 1..16.
REQ-003 SHALL have parameter DataWidth, default 64: CD data width.
REQ-004 SHALL have parameter IdxWidth, default 2: width of the initiator index.
REQ-005 SHALL define CRRESP bits as [4] WasUnique, [3] IsShared, [2] PassDirty, [1] Error, [0] DataTransfer.
REQ-006 Clock and reset ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
REQ-007 Control input ports:
- ctrl_valid_i  in  1  new snoop issued.
- ctrl_ready_o  out  1  queue has space.
- ctrl_sel_i  in  NumOup  targeted caches.
- ctrl_idx_i  in  IdxWidth  initiator index.
REQ-008 Per-cache CR ports:
- cr_valids_i  in  NumOup.
- cr_readies_o  out  NumOup.
- cr_resps_i  in  NumOup*5.
REQ-009 Per-cache CD ports:
- cd_valids_i  in  NumOup.
- cd_readies_o  out  NumOup.
- cd_datas_i  in  NumOup*DataWidth.
- cd_lasts_i  in  NumOup.
REQ-010 Merged CR output ports:
- cr_valid_o  out  1.
- cr_ready_i  in  1.
- cr_resp_o  out  5.
- cr_idx_o  out  IdxWidth.
REQ-011 Forwarded CD output ports:
- cd_valid_o  out  1.
- cd_ready_i  in  1.
- cd_data_o  out  DataWidth.
- cd_last_o  out  1.
- cd_idx_o  out  IdxWidth.
REQ-012 Status port: busy_o  out  1  queue non-empty or head transaction active.

Function
REQ-013 Control entries SHALL be queued FIFO, MaxTrans deep; ctrl_ready_o=0 when full, even if the head retires in the same cycle.
REQ-014 The head transaction SHALL follow FSM IDLE -> COLLECT -> RESP -> DATA -> IDLE.
REQ-015 COLLECT: cr_readies_o[i]=1 only for i in head sel and not yet collected; accepted responses SHALL be stored in a collected mask and merged by OR over all five bits.
REQ-016 Non-selected or already-collected ports SHALL see cr_readies_o=0 and cd_readies_o=0.
REQ-017 The FSM SHALL leave COLLECT on the cycle after the collected mask equals sel; simultaneous responses from several ports in one cycle SHALL all be accepted.
REQ-018 Empty sel SHALL go IDLE -> RESP with a merged response of 0.
REQ-019 PassDirty from more than one port SHALL additionally set Error.
REQ-020 RESP: cr_valid_o=1 with registered merged response and idx; held stable until cr_ready_i.
REQ-021 The owner SHALL be the lowest-index port with DataTransfer.
REQ-022 DATA: owner CD beats SHALL pass combinationally to the output (cd_valid_o = owner valid, cd_readies_o[owner] = cd_ready_i).
REQ-023 Other DataTransfer ports SHALL be drained (ready=1, data dropped) concurrently.
REQ-024 DATA SHALL exit when every DataTransfer port has delivered its last beat; with no DataTransfer, RESP goes straight to IDLE.
REQ-025 Head pop SHALL occur on DATA exit, or on RESP exit when there is no data; the next head SHALL enter COLLECT the following cycle.
REQ-026 Minimum latency SHALL be 1 cycle from the last CR accept to cr_valid_o; transactions SHALL complete in order.

Reset
REQ-027 Reset SHALL yield: FSM IDLE, queue empty, masks cleared.
REQ-028 All valid/ready outputs SHALL be 0 and data outputs 0 while rst_ni=0.
REQ-029 Reset mid-transaction SHALL discard all state, with no output after deassertion until new ctrl.

Structure
REQ-030 Package ace_pkg SHALL hold CRRESP bit-index constants and the FSM state enum.
REQ-031 The queue SHALL instantiate stream_fifo_optimal_wrap; one sub-module, ace_ccu_cr_merge (combinational OR/Error merge), SHALL be used.

Verification
REQ-032 sel=0b11, CR0=0x08, CR1=0x00 -> cr_resp_o=0x08, idx echoed, one cycle after 2nd accept.
REQ-033 sel=0b11, CR0=0x05, CR1=0x01, 4 beats each -> port0 beats forwarded in order, port1 drained, cd_last_o once.
REQ-034 sel=0b101, both PassDirty (0x04) -> cr_resp_o=0x06.
REQ-035 sel=0 -> cr_resp_o=0x00 within 2 cycles, no CD.
REQ-036 MaxTrans+1 back-to-back ctrl with cr_ready_i stalled -> ctrl_ready_o=0 after MaxTrans; all complete in order when released.
REQ-037 rst_ni pulsed during DATA beat 2 of 4 -> all outputs 0 and busy_o=0 after reset; next snoop correct.
